char_pixel_gen: RTL and testbench
=================================

// Module: char_pixel_gen
// PURPOSE
//  Downstream of the font-ROM address stage. Consumes the font ROM row byte for
//  the current scan line and turns it into RGB pixels for one 8x16 glyph at
//  (loc_x, loc_y). Delays hsync/vsync/video_on by the same amount, so the VGA
//  output port receives rgb and syncs aligned. Sits between font ROM and VGA pins.
// PARAMETERS
//  ROM_LAT    1       font ROM read latency in clk cycles (1..4)
//  GLYPH_W    8       glyph width in pixels (bits per ROM byte)
//  GLYPH_H    16      glyph height in rows
//  RGB_W      12      colour width (4:4:4)
//  SYNC_IDLE  1'b1    reset/idle level of hsync_o and vsync_o
// PORTS
//  clk        in   1      pixel clock
//  rst        in   1      synchronous reset, active-high
//  hcnt       in   12     current horizontal pixel count
//  vcnt       in   12     current vertical line count
//  loc_x      in   12     glyph left column
//  loc_y      in   12     glyph top line
//  video_on   in   1      visible-area flag, aligned with hcnt/vcnt
//  hsync_i    in   1      hsync, aligned with hcnt/vcnt
//  vsync_i    in   1      vsync, aligned with hcnt/vcnt
//  char_en    in   1      1 = draw glyph, 0 = background only
//  rom_data   in   8      font ROM row, valid ROM_LAT cycles after hcnt/vcnt
//  fg_color   in   RGB_W  colour for set glyph bits
//  bg_color   in   RGB_W  colour for cleared bits and outside the glyph box
//  rgb_o      out  RGB_W  pixel colour
//  hsync_o    out  1      delayed hsync
//  vsync_o    out  1      delayed vsync
//  pix_on_o   out  1      1 = rgb_o shows a set glyph bit (debug/overlay)
// BEHAVIOUR
//  - Reset: rgb_o=0, pix_on_o=0, hsync_o=vsync_o=SYNC_IDLE. All delay-line stages
//    are cleared to the same values, with video_on stages at 0. Reset mid-frame:
//    outputs stay at reset values until ROM_LAT+1 valid cycles after rst falls.
//  - Stage S0 (same cycle as hcnt): compute the box flag and column.
//    in_box = char_en && hcnt>=loc_x && hcnt<loc_x+GLYPH_W && vcnt>=loc_y &&
//    vcnt<loc_y+GLYPH_H. Add in 13 bits so there is no wrap-around. A glyph near
//    4095 is clipped and never wraps to column 0.
//    col = (hcnt-loc_x)[2:0].
//  - Delay {in_box, col, video_on, hsync_i, vsync_i} by ROM_LAT registers.
//  - Select stage, registered: bit = rom_data[GLYPH_W-1-col_d], so the MSB is the
//    leftmost pixel.
//    rgb_o = !video_on_d ? 0 : (in_box_d && bit) ? fg_color : bg_color.
//    pix_on_o = video_on_d & in_box_d & bit.
//    hsync_o and vsync_o take their delayed values.
//  - Total latency: hcnt/vcnt -> rgb_o/syncs is exactly ROM_LAT+1 cycles.
//    Throughput is 1 pixel/clk with no stalls.
//  - fg_color, bg_color, loc_x, loc_y and char_en are sampled unregistered each
//    cycle. A change takes effect at S0 of the next pixel; no frame-boundary
//    latching is done.
//  - rom_data outside the box is ignored, even if it is X.
//  - hcnt/vcnt wrap (end of line/frame) needs no special handling; the pipeline
//    is purely streaming.
// STRUCTURE
//  - Shared package/include vga_pkg: GLYPH_W, GLYPH_H, RGB_W, 800x600 timing
//    constants, RGB_BLACK=12'h000.
//  - Sub-module: sig_delay #(WIDTH, DEPTH, RST_VAL) is a synchronous-reset shift
//    register. Instantiate it once for {in_box,col,video_on,hsync,vsync} with
//    DEPTH=ROM_LAT.
//  - Top-level: S0 compare logic, sig_delay, and the output register.
// TESTING
//  1. Reset: rst=1 for 3 clk with random inputs -> rgb_o=0, hsync_o=vsync_o=1,
//     pix_on_o=0. These hold for ROM_LAT+1 clk after rst falls.
//  2. Glyph row: loc=(100,50), vcnt=53, char_en=1, video_on=1, ROM model
//     returns 8'b1000_0001, fg=FFF, bg=00F -> hcnt=100 and 107 give FFF,
//     hcnt=101..106 give 00F, hcnt=108 gives 00F; each ROM_LAT+1 clk later.
//  3. Latency/alignment: ROM_LAT=1 and 3, hsync_i pulse at hcnt=840 -> hsync_o
//     toggles exactly 2 resp. 4 clk later, in the same cycle as the matching rgb.
//  4. Blanking: video_on=0 inside the box with rom_data=FF -> rgb_o=000,
//     pix_on_o=0.
//  5. Edges: vcnt=loc_y+16 or hcnt=loc_x-1 -> bg. loc_x=4092 with hcnt=0..3
//     -> bg (no wrap). char_en=0 -> bg across the whole box.
//  6. Reset mid-frame while drawing -> outputs go to reset values on the next
//     edge; drawing resumes, correct, ROM_LAT+1 clk after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants: glyph geometry, colour width, 800x600@60 timing and helpers.
package vga_pkg;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 16;
    localparam int unsigned RGB_W   = 12;

    localparam int unsigned H_VISIBLE = 800;
    localparam int unsigned H_FRONT   = 40;
    localparam int unsigned H_SYNC    = 128;
    localparam int unsigned H_BACK    = 88;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_VISIBLE = 600;
    localparam int unsigned V_FRONT   = 1;
    localparam int unsigned V_SYNC    = 4;
    localparam int unsigned V_BACK    = 23;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;

    // start <= pos < start+len, evaluated one bit wider so a span near the top clips instead of wrapping
    function automatic logic in_span(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] start,
                                     input int unsigned      len);
        logic [CNT_W:0] p;
        logic [CNT_W:0] s;
        p = {1'b0, pos};
        s = {1'b0, start};
        return (p >= s) && (p < s + (CNT_W+1)'(len));
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with synchronous reset to a programmable value.
module sig_delay #(
    parameter int unsigned     WIDTH   = 1,
    parameter int unsigned     DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/char_pixel_gen.sv
// Turns a font ROM row byte into RGB for one glyph box, with syncs delayed to match.
module char_pixel_gen #(
    parameter int unsigned ROM_LAT   = 1,
    parameter int unsigned GLYPH_W   = vga_pkg::GLYPH_W,
    parameter int unsigned GLYPH_H   = vga_pkg::GLYPH_H,
    parameter int unsigned RGB_W     = vga_pkg::RGB_W,
    parameter logic        SYNC_IDLE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [vga_pkg::CNT_W-1:0]  hcnt,
    input  logic [vga_pkg::CNT_W-1:0]  vcnt,
    input  logic [vga_pkg::CNT_W-1:0]  loc_x,
    input  logic [vga_pkg::CNT_W-1:0]  loc_y,
    input  logic                       video_on,
    input  logic                       hsync_i,
    input  logic                       vsync_i,
    input  logic                       char_en,
    input  logic [GLYPH_W-1:0]         rom_data,
    input  logic [RGB_W-1:0]           fg_color,
    input  logic [RGB_W-1:0]           bg_color,
    output logic [RGB_W-1:0]           rgb_o,
    output logic                       hsync_o,
    output logic                       vsync_o,
    output logic                       pix_on_o
);

    localparam int unsigned COL_W = $clog2(GLYPH_W);
    localparam int unsigned TAG_W = COL_W + 4;
    localparam logic [TAG_W-1:0] TAG_RST = {1'b0, {COL_W{1'b0}}, 1'b0, SYNC_IDLE, SYNC_IDLE};

    logic             in_box_c;
    logic [COL_W-1:0] col_c;
    logic [TAG_W-1:0] tag_s0;
    logic [TAG_W-1:0] tag_sel;

    logic             in_box_s;
    logic [COL_W-1:0] col_s;
    logic             video_on_s;
    logic             hsync_s;
    logic             vsync_s;

    logic [COL_W-1:0] px_idx;
    logic             px_bit;

    logic [RGB_W-1:0] rgb_d,    rgb_q;
    logic             pix_on_d, pix_on_q;
    logic             hsync_d,  hsync_q;
    logic             vsync_d,  vsync_q;

    // S0: glyph box test and column within the glyph, same cycle as hcnt/vcnt
    always_comb begin
        col_c    = COL_W'(hcnt - loc_x);
        in_box_c = char_en
                 && vga_pkg::in_span(hcnt, loc_x, GLYPH_W)
                 && vga_pkg::in_span(vcnt, loc_y, GLYPH_H);
    end

    assign tag_s0 = {in_box_c, col_c, video_on, hsync_i, vsync_i};

    sig_delay #(
        .WIDTH   (TAG_W),
        .DEPTH   (ROM_LAT),
        .RST_VAL (TAG_RST)
    ) u_tag_dly (
        .clk (clk),
        .rst (rst),
        .d   (tag_s0),
        .q   (tag_sel)
    );

    assign {in_box_s, col_s, video_on_s, hsync_s, vsync_s} = tag_sel;

    // Select: MSB of the ROM row is the leftmost pixel; ROM byte is only looked at inside the box
    always_comb begin
        rgb_d    = RGB_W'(vga_pkg::RGB_BLACK);
        pix_on_d = 1'b0;
        hsync_d  = hsync_s;
        vsync_d  = vsync_s;
        px_idx   = COL_W'(GLYPH_W - 1) - col_s;
        px_bit   = 1'b0;
        if (video_on_s) begin
            rgb_d = bg_color;
            if (in_box_s) begin
                px_bit = rom_data[px_idx];
                if (px_bit) begin
                    rgb_d    = fg_color;
                    pix_on_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q    <= '0;
            pix_on_q <= 1'b0;
            hsync_q  <= SYNC_IDLE;
            vsync_q  <= SYNC_IDLE;
        end else begin
            rgb_q    <= rgb_d;
            pix_on_q <= pix_on_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    assign rgb_o    = rgb_q;
    assign pix_on_o = pix_on_q;
    assign hsync_o  = hsync_q;
    assign vsync_o  = vsync_q;

endmodule

// File: tb/tb_char_pixel_gen.sv
// Directed bench for char_pixel_gen at ROM_LAT=1 and ROM_LAT=3 driven in lockstep.
module tb_char_pixel_gen;

    localparam int MAXV = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] hcnt, vcnt, loc_x, loc_y;
    logic        video_on, hsync_i, vsync_i, char_en;
    logic [11:0] fg_color, bg_color;
    logic [7:0]  rom_row_v;
    logic [7:0]  rom_pipe [3];

    logic [11:0] rgb1, rgb3;
    logic        pix1, pix3, hs1, hs3, vs1, vs3;

    logic [11:0] e_rgb [MAXV];
    bit          e_pix [MAXV];
    bit          e_hs  [MAXV];
    bit          e_vs  [MAXV];
    bit          rst_hist [MAXV];
    int          nv       = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    // Font ROM stand-in: returns the row the stimulus chose, delayed 1 and 3 clocks
    always @(posedge clk) begin
        rom_pipe[0] <= rom_row_v;
        rom_pipe[1] <= rom_pipe[0];
        rom_pipe[2] <= rom_pipe[1];
    end

    char_pixel_gen #(.ROM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .loc_x(loc_x), .loc_y(loc_y),
        .video_on(video_on), .hsync_i(hsync_i), .vsync_i(vsync_i), .char_en(char_en),
        .rom_data(rom_pipe[0]), .fg_color(fg_color), .bg_color(bg_color),
        .rgb_o(rgb1), .hsync_o(hs1), .vsync_o(vs1), .pix_on_o(pix1)
    );

    char_pixel_gen #(.ROM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .loc_x(loc_x), .loc_y(loc_y),
        .video_on(video_on), .hsync_i(hsync_i), .vsync_i(vsync_i), .char_en(char_en),
        .rom_data(rom_pipe[2]), .fg_color(fg_color), .bg_color(bg_color),
        .rgb_o(rgb3), .hsync_o(hs3), .vsync_o(vs3), .pix_on_o(pix3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Output in cycle c belongs to the vector of cycle c-lat-1, unless rst was high on its way through
    task automatic chk_out(input int lat, input int c, input logic [11:0] rgb,
                           input logic pix, input logic hs, input logic vs);
        int t;
        bit flushed;
        logic [11:0] xr;
        logic xp, xh, xv;
        t = c - lat - 1;
        if (t < 0) return;
        flushed = 1'b0;
        for (int k = t; k < c; k++) if (rst_hist[k]) flushed = 1'b1;
        if (flushed) begin
            xr = 12'h000; xp = 1'b0; xh = 1'b1; xv = 1'b1;
        end else begin
            xr = e_rgb[t]; xp = e_pix[t]; xh = e_hs[t]; xv = e_vs[t];
        end
        check($sformatf("rgb_l%0d_v%0d", lat, t),    32'(rgb), 32'(xr));
        check($sformatf("pix_on_l%0d_v%0d", lat, t), 32'(pix), 32'(xp));
        check($sformatf("hsync_l%0d_v%0d", lat, t),  32'(hs),  32'(xh));
        check($sformatf("vsync_l%0d_v%0d", lat, t),  32'(vs),  32'(xv));
    endtask

    always @(negedge clk) begin
        if (nv > 0) begin
            chk_out(1, nv - 1, rgb1, pix1, hs1, vs1);
            chk_out(3, nv - 1, rgb3, pix3, hs3, vs3);
        end
    end

    // One pixel per call: drive inputs just after the edge and record the hand-computed result
    task automatic vec(input logic r, input logic [11:0] h, input logic [11:0] v,
                       input logic von, input logic hs, input logic vs,
                       input logic [7:0] row, input logic [11:0] er, input logic ep);
        @(posedge clk);
        #1;
        rst = r; hcnt = h; vcnt = v; video_on = von; hsync_i = hs; vsync_i = vs;
        rom_row_v = row;
        if (nv < MAXV) begin
            rst_hist[nv] = r; e_rgb[nv] = er; e_pix[nv] = ep; e_hs[nv] = hs; e_vs[nv] = vs;
            nv++;
        end
    endtask

    task automatic px(input logic [11:0] h, input logic [11:0] v, input logic [7:0] row,
                      input logic [11:0] er, input logic ep);
        vec(1'b0, h, v, 1'b1, 1'b1, 1'b1, row, er, ep);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) vec(1'b0, 12'd900, 12'd53, 1'b0, 1'b1, 1'b1, 8'h00, 12'h000, 1'b0);
    endtask

    initial begin
        rst = 1'b1; hcnt = '0; vcnt = '0; video_on = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
        rom_row_v = 8'h00; loc_x = 12'd100; loc_y = 12'd50; char_en = 1'b1;
        fg_color = 12'hFFF; bg_color = 12'h00F;

        for (int i = 0; i < 3; i++)
            vec(1'b1, 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom), 12'h000, 1'b0);

        // Glyph row 0x81 at vcnt=53; first pixels after release are still held at reset values
        for (int h = 96; h <= 108; h++)
            px(12'(h), 12'd53, 8'h81, (h == 100 || h == 107) ? 12'hFFF : 12'h00F,
               (h == 100 || h == 107));
        idle(4);

        for (int h = 838; h <= 844; h++)
            vec(1'b0, 12'(h), 12'd53, 1'b0, (h != 840), (h != 842), 8'h00, 12'h000, 1'b0);

        for (int h = 100; h <= 103; h++)
            vec(1'b0, 12'(h), 12'd53, 1'b0, 1'b1, 1'b1, 8'hFF, 12'h000, 1'b0);
        px(12'd104, 12'd53, 8'hFF, 12'hFFF, 1'b1);

        px(12'd100, 12'd66, 8'hFF, 12'h00F, 1'b0);
        px(12'd100, 12'd65, 8'hFF, 12'hFFF, 1'b1);
        px(12'd100, 12'd49, 8'hFF, 12'h00F, 1'b0);
        px(12'd99,  12'd53, 8'hFF, 12'h00F, 1'b0);
        px(12'd108, 12'd53, 8'hFF, 12'h00F, 1'b0);
        px(12'd107, 12'd50, 8'hFF, 12'hFFF, 1'b1);

        idle(5);
        loc_x = 12'd4092;
        for (int h = 0; h <= 3; h++)       px(12'(h), 12'd53, 8'hFF, 12'h00F, 1'b0);
        for (int h = 4092; h <= 4095; h++) px(12'(h), 12'd53, 8'hFF, 12'hFFF, 1'b1);

        idle(5);
        loc_x = 12'd100; char_en = 1'b0;
        for (int h = 100; h <= 107; h++) px(12'(h), 12'd53, 8'hFF, 12'h00F, 1'b0);

        idle(5);
        char_en = 1'b1; fg_color = 12'h0A5; bg_color = 12'h321;
        px(12'd99,  12'd53, 8'h60, 12'h321, 1'b0);
        px(12'd100, 12'd53, 8'h60, 12'h321, 1'b0);
        px(12'd101, 12'd53, 8'h60, 12'h0A5, 1'b1);
        px(12'd102, 12'd53, 8'h60, 12'h0A5, 1'b1);
        px(12'd103, 12'd53, 8'h60, 12'h321, 1'b0);

        idle(5);
        fg_color = 12'hFFF; bg_color = 12'h00F;
        // One-cycle reset in the middle of a drawn row, then the row again
        for (int h = 100; h <= 107; h++)
            vec((h == 103), 12'(h), 12'd53, 1'b1, 1'b1, 1'b1, 8'h81,
                (h == 100 || h == 107) ? 12'hFFF : 12'h00F, (h == 100 || h == 107));
        for (int h = 100; h <= 107; h++)
            px(12'(h), 12'd53, 8'h81, (h == 100 || h == 107) ? 12'hFFF : 12'h00F,
               (h == 100 || h == 107));
        idle(6);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
